// File: rtl/hwpe_ctrl_ctx_scheduler.sv
// Job-context scheduler: grants, queues and sequences the engine over N_CONTEXT slots.
// Responses registered (1 cycle); trigger->start 2 cycles; no backpressure, refusals via ok=0/trigger_err.
module hwpe_ctrl_ctx_scheduler #(
  parameter  int unsigned N_CONTEXT = 2,
  parameter  int unsigned N_CORES   = 16,
  parameter  int unsigned N_EVT     = 2,
  parameter  int unsigned ID_WIDTH  = 4,
  localparam int unsigned CTX_W     = $clog2(N_CONTEXT),
  localparam int unsigned CNT_W     = CTX_W + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           acquire_req_i,
  input  logic [ID_WIDTH-1:0]            acquire_id_i,
  output logic                           acquire_rsp_o,
  output logic                           acquire_ok_o,
  output logic [CTX_W-1:0]               acquire_ctx_o,
  input  logic                           trigger_i,
  input  logic [ID_WIDTH-1:0]            trigger_id_i,
  output logic                           trigger_err_o,
  output logic                           start_o,
  output logic [CTX_W-1:0]               running_ctx_o,
  output logic [CTX_W-1:0]               pointer_ctx_o,
  input  logic                           done_i,
  output logic                           ctx_free_o,
  output logic [N_CORES-1:0][N_EVT-1:0]  evt_o,
  output logic                           is_working_o,
  output logic [CNT_W-1:0]               n_free_o
);

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ACQ, SLOT_QUEUED, SLOT_RUN} slot_e;
  typedef enum logic [1:0] {ENG_IDLE, ENG_START, ENG_RUN} eng_e;

  slot_e                          slot_q  [N_CONTEXT];
  slot_e                          slot_d  [N_CONTEXT];
  logic [ID_WIDTH-1:0]            owner_q [N_CONTEXT];
  logic [ID_WIDTH-1:0]            owner_d [N_CONTEXT];
  logic [CTX_W-1:0]               pointer_q, pointer_d;
  logic [CTX_W-1:0]               running_q;
  logic                           acq_rsp_q, acq_rsp_d;
  logic                           acq_ok_q, acq_ok_d;
  logic [CTX_W-1:0]               acq_ctx_q, acq_ctx_d;
  logic                           trig_err_q, trig_err_d;
  logic [CNT_W-1:0]               n_free_q, n_free_d;
  eng_e                           state_q;
  logic                           start_q, ctx_free_q;
  logic [N_CORES-1:0][N_EVT-1:0]  evt_q, evt_dec;
  logic                           any_acq;

  always_comb begin
    slot_d     = slot_q;
    owner_d    = owner_q;
    pointer_d  = pointer_q;
    acq_rsp_d  = acquire_req_i;
    acq_ok_d   = 1'b0;
    acq_ctx_d  = '0;
    trig_err_d = 1'b0;
    n_free_d   = '0;
    evt_dec    = '0;
    any_acq    = 1'b0;

    for (int k = 0; k < N_CONTEXT; k++) begin
      if (slot_q[k] == SLOT_ACQ) any_acq = 1'b1;
    end

    // Acquire and trigger are mutually exclusive on the pointer slot: grant needs no holder,
    // trigger needs one, so their slot writes never collide.
    if (acquire_req_i && (slot_q[pointer_q] == SLOT_FREE) && !any_acq) begin
      slot_d[pointer_q]  = SLOT_ACQ;
      owner_d[pointer_q] = acquire_id_i;
      acq_ok_d           = 1'b1;
      acq_ctx_d          = pointer_q;
    end

    if (trigger_i) begin
      if ((slot_q[pointer_q] == SLOT_ACQ) && (owner_q[pointer_q] == trigger_id_i)) begin
        slot_d[pointer_q] = SLOT_QUEUED;
        pointer_d         = pointer_q + 1'b1;
      end else begin
        trig_err_d = 1'b1;
      end
    end

    if (state_q == ENG_START) slot_d[running_q] = SLOT_RUN;
    if ((state_q == ENG_RUN) && done_i) slot_d[running_q] = SLOT_FREE;

    // Owners outside the core range match no line, so their event is dropped.
    for (int c = 0; c < N_CORES; c++) begin
      if (owner_q[running_q] == ID_WIDTH'(c)) evt_dec[c][0] = 1'b1;
    end

    if (clear_i) begin
      for (int k = 0; k < N_CONTEXT; k++) begin
        slot_d[k]  = SLOT_FREE;
        owner_d[k] = '0;
      end
      pointer_d  = '0;
      acq_rsp_d  = 1'b0;
      acq_ok_d   = 1'b0;
      acq_ctx_d  = '0;
      trig_err_d = 1'b0;
    end

    for (int k = 0; k < N_CONTEXT; k++) begin
      if (slot_d[k] == SLOT_FREE) n_free_d = n_free_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_CONTEXT; k++) begin
        slot_q[k]  <= SLOT_FREE;
        owner_q[k] <= '0;
      end
      pointer_q  <= '0;
      acq_rsp_q  <= 1'b0;
      acq_ok_q   <= 1'b0;
      acq_ctx_q  <= '0;
      trig_err_q <= 1'b0;
      n_free_q   <= CNT_W'(N_CONTEXT);
    end else begin
      slot_q     <= slot_d;
      owner_q    <= owner_d;
      pointer_q  <= pointer_d;
      acq_rsp_q  <= acq_rsp_d;
      acq_ok_q   <= acq_ok_d;
      acq_ctx_q  <= acq_ctx_d;
      trig_err_q <= trig_err_d;
      n_free_q   <= n_free_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ENG_IDLE;
      running_q  <= '0;
      start_q    <= 1'b0;
      ctx_free_q <= 1'b0;
      evt_q      <= '0;
    end else if (clear_i) begin
      state_q    <= ENG_IDLE;
      running_q  <= '0;
      start_q    <= 1'b0;
      ctx_free_q <= 1'b0;
      evt_q      <= '0;
    end else begin
      start_q    <= 1'b0;
      ctx_free_q <= 1'b0;
      evt_q      <= '0;
      case (state_q)
        ENG_IDLE: begin
          if (slot_q[running_q] == SLOT_QUEUED) begin
            state_q <= ENG_START;
            start_q <= 1'b1;
          end
        end
        ENG_START: state_q <= ENG_RUN;
        ENG_RUN: begin
          if (done_i) begin
            state_q    <= ENG_IDLE;
            running_q  <= running_q + 1'b1;
            ctx_free_q <= 1'b1;
            evt_q      <= evt_dec;
          end
        end
        default: state_q <= ENG_IDLE;
      endcase
    end
  end

  assign acquire_rsp_o = acq_rsp_q;
  assign acquire_ok_o  = acq_ok_q;
  assign acquire_ctx_o = acq_ctx_q;
  assign trigger_err_o = trig_err_q;
  assign start_o       = start_q;
  assign running_ctx_o = running_q;
  assign pointer_ctx_o = pointer_q;
  assign ctx_free_o    = ctx_free_q;
  assign evt_o         = evt_q;
  assign is_working_o  = (state_q != ENG_IDLE);
  assign n_free_o      = n_free_q;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_scheduler.sv
// Bench for hwpe_ctrl_ctx_scheduler: directed scenarios plus random traffic against a job-queue model.
module tb_hwpe_ctrl_ctx_scheduler;
  localparam int NC    = 2;
  localparam int NCORE = 16;
  localparam int NEVT  = 2;
  localparam int IDW   = 4;
  localparam int CW    = $clog2(NC);

  logic                        clk = 1'b0;
  logic                        rst_ni;
  logic                        clear, acq, trg, done;
  logic [IDW-1:0]              aid, tid;
  logic                        rsp, ok, terr, start, cfree, working;
  logic [CW-1:0]               actx, run_ctx, ptr_ctx;
  logic [NCORE-1:0][NEVT-1:0]  evt;
  logic [CW:0]                 nfree;

  always #5 clk = ~clk;

  hwpe_ctrl_ctx_scheduler #(
    .N_CONTEXT(NC), .N_CORES(NCORE), .N_EVT(NEVT), .ID_WIDTH(IDW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear),
    .acquire_req_i(acq), .acquire_id_i(aid), .acquire_rsp_o(rsp),
    .acquire_ok_o(ok), .acquire_ctx_o(actx),
    .trigger_i(trg), .trigger_id_i(tid), .trigger_err_o(terr),
    .start_o(start), .running_ctx_o(run_ctx), .pointer_ctx_o(ptr_ctx),
    .done_i(done), .ctx_free_o(cfree), .evt_o(evt),
    .is_working_o(working), .n_free_o(nfree)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: at most one held (acquired) context, then an ordered list of committed jobs
  // whose head is the one the engine works on; phase 0 idle, 1 start, 2 run.
  bit              m_held;
  int              m_hc, m_ho;
  int              m_jo[$];
  int              m_phase, m_ptr, m_run;
  bit              e_rsp, e_ok, e_err, e_start, e_free;
  int              e_ctx;
  logic [63:0]     e_evt;

  task automatic model_reset();
    m_held = 0; m_hc = 0; m_ho = 0; m_jo.delete();
    m_phase = 0; m_ptr = 0; m_run = 0;
    e_rsp = 0; e_ok = 0; e_err = 0; e_start = 0; e_free = 0; e_ctx = 0; e_evt = '0;
  endtask

  task automatic model_step();
    bit can_acq, trig_ok;
    int o;
    e_rsp = 0; e_ok = 0; e_err = 0; e_start = 0; e_free = 0; e_ctx = 0; e_evt = '0;
    if (!rst_ni || clear) begin
      model_reset();
      return;
    end
    can_acq = !m_held && (m_jo.size() < NC);
    trig_ok = m_held && (m_ho == int'(tid));
    case (m_phase)
      0: if (m_jo.size() > 0) begin m_phase = 1; e_start = 1; end
      1: m_phase = 2;
      default: if (done) begin
        o = m_jo.pop_front();
        e_free = 1;
        if (o < NCORE) e_evt[o*NEVT] = 1'b1;
        m_run = (m_run + 1) % NC;
        m_phase = 0;
      end
    endcase
    e_rsp = acq;
    if (acq && can_acq) begin
      m_held = 1; m_hc = m_ptr; m_ho = int'(aid);
      e_ok = 1; e_ctx = m_ptr;
    end
    if (trg) begin
      if (trig_ok) begin
        m_jo.push_back(m_ho);
        m_held = 0;
        m_ptr = (m_ptr + 1) % NC;
      end else begin
        e_err = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("rsp",      64'(rsp),     64'(e_rsp));
    chk("ok",       64'(ok),      64'(e_ok));
    chk("ctx",      64'(actx),    64'(e_ctx));
    chk("trig_err", 64'(terr),    64'(e_err));
    chk("start",    64'(start),   64'(e_start));
    chk("ctx_free", 64'(cfree),   64'(e_free));
    chk("evt",      64'(evt),     e_evt);
    chk("working",  64'(working), 64'(m_phase != 0));
    chk("n_free",   64'(nfree),   64'(NC - int'(m_held) - m_jo.size()));
    chk("pointer",  64'(ptr_ctx), 64'(m_ptr));
    chk("running",  64'(run_ctx), 64'(m_run));
  endtask

  task automatic cyc(input bit a, input int ai, input bit t, input int ti, input bit d, input bit c);
    acq = a; aid = IDW'(ai); trg = t; tid = IDW'(ti); done = d; clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_ni = 1'b0; clear = 0; acq = 0; trg = 0; done = 0; aid = '0; tid = '0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    chk("rst_nfree", 64'(nfree), 64'(2));
    rst_ni = 1'b1;

    // single job, id 3
    cyc(1, 3, 0, 0, 0, 0);
    chk("s2_ok", 64'(ok), 64'(1));
    chk("s2_ctx", 64'(actx), 64'(0));
    cyc(0, 0, 1, 3, 0, 0);
    chk("s2_nostart_t1", 64'(start), 64'(0));
    idle(1);
    chk("s2_start_t2", 64'(start), 64'(1));
    idle(2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s2_evt3", 64'(evt[3][0]), 64'(1));
    chk("s2_nfree", 64'(nfree), 64'(2));
    idle(1);

    // two queued jobs, third acquire refused
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);
    cyc(1, 4, 0, 0, 0, 0);
    chk("s3_full_ok", 64'(ok), 64'(0));
    idle(2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s3_evt1", 64'(evt[1][0]), 64'(1));
    idle(1);
    chk("s3_start_ctx1", 64'(start), 64'(1));
    chk("s3_run_ctx1", 64'(run_ctx), 64'(1));
    idle(2);

    // wrong-owner trigger
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 5, 0, 0, 0, 0);
    cyc(0, 0, 1, 6, 0, 0);
    chk("s4_err", 64'(terr), 64'(1));
    idle(2);
    cyc(0, 0, 1, 5, 0, 0);
    idle(1);
    chk("s4_start", 64'(start), 64'(1));
    idle(2);

    // acquire races the done that frees ctx0
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    idle(3);
    cyc(1, 2, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);
    cyc(1, 7, 0, 0, 1, 0);
    chk("s5_race_ok", 64'(ok), 64'(0));
    cyc(1, 7, 0, 0, 0, 0);
    chk("s5_retry_ok", 64'(ok), 64'(1));
    chk("s5_retry_ctx", 64'(actx), 64'(0));
    idle(3);

    // clear while running
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(0, 0, 1, 9, 0, 0);
    idle(3);
    chk("s6_working", 64'(working), 64'(1));
    cyc(0, 0, 0, 0, 0, 1);
    chk("s6_clr_working", 64'(working), 64'(0));
    chk("s6_clr_nfree", 64'(nfree), 64'(2));
    cyc(0, 0, 0, 0, 1, 0);
    chk("s6_no_evt", 64'(evt), 64'(0));
    chk("s6_no_free", 64'(cfree), 64'(0));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit a, t, d, c;
      int ai, ti;
      a  = ($urandom_range(0, 3) == 0);
      ai = int'($urandom_range(0, NCORE - 1));
      t  = ($urandom_range(0, 3) == 0);
      ti = (m_held && ($urandom_range(0, 3) != 0)) ? m_ho : int'($urandom_range(0, NCORE - 1));
      d  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 199) == 0);
      cyc(a, ai, t, ti, d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
